fma_pipe_param: RTL and testbench
=================================

Name: fma_pipe_param

Overview:
- Parameterised, pipelined fused multiply-add for small IEEE-style floats. Computes R = (±A×B) ± C with a single final rounding. Default format is bfloat16.
- Successor to the combinational bfloat16 multiply-then-add datapath, adding:
  - configurable exponent/mantissa widths;
  - op modes (FMA/MUL/ADD) with per-operand negation;
  - a 3-stage registered pipeline with valid/ready handshake;
  - sticky exception flags.
- Sits between an operand source (scratchpad/sequencer) and a result sink in the accelerator datapath.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 7, stored mantissa width, hidden bit excluded. Total word width W = 1+EXP_W+MAN_W.
- FLUSH_DENORM, 1, denormal inputs and outputs are treated as signed zero. This is the only mode implemented.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  block accepts the operand set this cycle.
- a, b, c  in  W each  operands.
- op  in  2  0=FMA (A×B+C), 1=MUL (C forced +0), 2=ADD (B forced 1.0), 3=reserved (behaves as FMA).
- neg_p  in  1  negate product.
- neg_c  in  1  negate addend.
- out_valid  out  1  result present.
- out_ready  in  1  sink accepts result.
- result  out  W  rounded result.
- ov  out  1  this result overflowed to ±Inf.
- nv  out  1  this result is an invalid operation, producing NaN.
- ov_sticky  out  1  OR of every ov since last clear.
- nv_sticky  out  1  OR of every nv since last clear.
- flag_clr  in  1  synchronous clear of the sticky flags.

Behaviour:
- Reset (async, immediate): all stage valids=0, out_valid=0, result=0, ov=nv=0, ov_sticky=nv_sticky=0. in_ready=1 once rst deasserts.
- Pipeline structure:
  - S1: unpack, special detect, mantissa product (2·(MAN_W+1) bits).
  - S2: exponent compare, align addend against the unrounded product with guard/round/sticky.
  - S3: add/subtract, leading-zero normalise, round-to-nearest-even, pack.
- Latency: exactly 3 cycles from the accepting edge to out_valid when unstalled. Throughput 1 result/cycle.
- Handshake:
  - Transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
  - in_ready = !s3_valid || out_ready || bubble present in S1/S2 (per-stage stall: a stage advances if the next stage is empty or advancing).
  - result/ov/nv are held stable while out_valid && !out_ready.
  - No operand is ever dropped or duplicated.
- Arithmetic rules:
  - Product is exact, never rounded before the add.
  - Exponent bias = 2^(EXP_W-1)-1.
  - Exact zero result is +0, except (−0)+(−0) = −0.
  - Finite overflow gives ±Inf (exp all-ones, mantissa 0) and ov=1.
  - Underflow below min normal flushes to signed zero. No flag is raised.
- Special values:
  - Any NaN input, Inf×0, or Inf−Inf (including product Inf against addend Inf of opposite effective sign) gives canonical qNaN (sign 0, exp all-ones, mantissa MSB=1, rest 0).
  - nv=1 only for Inf×0 and Inf−Inf. NaN propagation alone sets nv=0.
  - Inf operands otherwise give correctly signed Inf with ov=0.
- Sticky flags:
  - Set on output transfer of a result whose ov or nv is 1.
  - flag_clr clears them next edge. If flag_clr coincides with a flagging transfer, the set wins.
- Mode/negation is sampled with its operands and travels with them. Changing op mid-stream affects only newly accepted sets.
- Reset mid-operation discards all in-flight results. Nothing emerges afterwards.

Test Plan:
- FMA basic: a=0x3FC0 (1.5), b=0x4000 (2), c=0x3F80 (1), op=0 -> result 0x4080 (4.0) exactly 3 cycles later, ov=nv=0. Then a=0x4000, b=0x4040, c=0x3F80 -> 0x40E0 (7.0).
- Single rounding / RNE: op=2, a=0x3F80, c=0x3B80 (2^-8) -> tie, rounds to even, 0x3F80. Then c=0x3BC0 (1.5·2^-8) -> 0x3F81. Cancellation: a=0x3F80, b=0x3F80, c=0xBF80 -> 0x0000.
- Overflow and sticky: a=0x7F7F, b=0x4000, c=0, op=1 -> 0x7F80, ov=1, ov_sticky=1. ov_sticky persists across later clean results. flag_clr pulse -> ov_sticky=0 next cycle.
- Invalid:
  - a=0x7F80, b=0x0000 -> 0x7FC0, nv=1.
  - a=0x7F80, b=0x3F80, c=0xFF80 -> 0x7FC0, nv=1.
  - a=0x7FC1 (NaN) -> 0x7FC0, nv=0.
- Back-pressure: stream 6 distinct operand sets with out_ready=0 -> in_ready falls after 3 accepts. result held stable. Release out_ready -> all 6 results emerge in order, none lost or repeated.
- Reset mid-flight: accept 2 sets, assert rst asynchronously between edges -> out_valid=0 immediately, no stale result after release. Then a fresh FMA returns correctly with 3-cycle latency.

Source files
------------

// File: rtl/fma_pipe_param_if.sv
// Operand/result handshake bundle between an operand source, fma_pipe_param and a result sink.
interface fma_pipe_param_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [1:0]   op;
  logic         neg_p;
  logic         neg_c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         ov;
  logic         nv;
  logic         ov_sticky;
  logic         nv_sticky;
  logic         flag_clr;

  modport master (
    output in_valid, a, b, c, op, neg_p, neg_c, out_ready, flag_clr,
    input  in_ready, out_valid, result, ov, nv, ov_sticky, nv_sticky
  );

  modport slave (
    input  in_valid, a, b, c, op, neg_p, neg_c, out_ready, flag_clr,
    output in_ready, out_valid, result, ov, nv, ov_sticky, nv_sticky
  );
endinterface

// File: rtl/fma_pipe_param.sv
// Three-stage fused multiply-add R = (+-A*B) +- C, single RNE rounding, denormals flushed to zero.
module fma_pipe_param #(
  parameter int EXP_W        = 8,
  parameter int MAN_W        = 7,
  parameter bit FLUSH_DENORM = 1'b1
) (
  input logic clk,
  input logic rst,
  fma_pipe_param_if.slave io
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int P   = MAN_W + 1;
  localparam int PW  = 2 * P;
  localparam int WE  = PW + 3;
  localparam int EW  = EXP_W + 3;
  localparam int SHW = $clog2(WE + 1);
  localparam int LZW = $clog2(WE + 2);
  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] WE_S  = EW'(WE);
  localparam logic signed [EW-1:0] ONE_E = EW'(1);
  localparam logic [W-1:0] ONE_W = {1'b0, 1'b0, {(EXP_W-1){1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-1:0] QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic is_nan; logic is_nv; logic is_inf; logic inf_sign;
    logic sp; logic pzero; logic signed [EW-1:0] pe; logic [PW-1:0] pm;
    logic sc; logic czero; logic [EXP_W-1:0] ce; logic [P-1:0] cm;
  } s1_t;

  typedef struct packed {
    logic is_nan; logic is_nv; logic is_inf; logic inf_sign;
    logic sx; logic sub; logic zsign; logic signed [EW-1:0] ex;
    logic [WE-1:0] mx; logic [WE-1:0] my;
  } s2_t;

  // {nan, inf, zero}
  function automatic logic [2:0] classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = x[W-2:MAN_W];
    m = x[MAN_W-1:0];
    return {(&e) & (|m), (&e) & ~(|m), (e == '0) & (FLUSH_DENORM | (m == '0))};
  endfunction

  function automatic logic [LZW-1:0] lzc(input logic [WE:0] v);
    logic [LZW-1:0] n;
    n = LZW'(WE + 1);
    for (int i = 0; i <= WE; i++) begin
      if (v[i]) n = LZW'(WE - i);
    end
    return n;
  endfunction

  logic v1_r, v2_r, v3_r, load1_s, load2_s, load3_s;
  s1_t  s1_d, r1_r;
  s2_t  s2_d, r2_r;
  logic [W-1:0] a_s, b_s, c_s, res_d, res_r;
  logic [2:0]   ca_s, cb_s, cc_s;
  logic sc_s, sp_s, any_nan_s, itz_s, pinf_s, imi_s, p_big_s, ov_d, nv_d;
  logic ov_r, nv_r, ovs_r, nvs_r, rsign_s, g_s, st_s, inc_s;
  logic signed [EW-1:0] pn_e_s, cn_e_s, ye_s, d_s, er_s, erf_s;
  logic [PW-1:0] pn_m_s, cn_m_s, ym_s;
  logic [SHW-1:0] shamt_s;
  logic [WE-1:0]  ext_s, mask_s;
  logic [WE:0]    sum_s, norm_s;
  logic [LZW-1:0] lz_s;
  logic [P-1:0]   top_s;
  logic [P:0]     rm_s;

  // A stage may load when it is empty or its content moves on this edge.
  assign load3_s     = ~v3_r | io.out_ready;
  assign load2_s     = ~v2_r | load3_s;
  assign load1_s     = ~v1_r | load2_s;
  assign io.in_ready = load1_s;

  // S1: mode overrides, unpack, special-case detection, exact mantissa product.
  always_comb begin
    a_s  = io.a;
    b_s  = io.b;
    c_s  = io.c;
    sc_s = io.c[W-1] ^ io.neg_c;
    case (io.op)
      2'd1:    begin c_s = '0; sc_s = 1'b0; end
      2'd2:    b_s = ONE_W;
      default: begin end
    endcase
    ca_s      = classify(a_s);
    cb_s      = classify(b_s);
    cc_s      = classify(c_s);
    sp_s      = a_s[W-1] ^ b_s[W-1] ^ io.neg_p;
    any_nan_s = ca_s[2] | cb_s[2] | cc_s[2];
    itz_s     = (ca_s[1] & cb_s[0]) | (ca_s[0] & cb_s[1]);
    pinf_s    = (ca_s[1] | cb_s[1]) & ~itz_s;
    imi_s     = pinf_s & cc_s[1] & (sp_s ^ sc_s);
    s1_d.is_nan   = any_nan_s | itz_s | imi_s;
    s1_d.is_nv    = ~any_nan_s & (itz_s | imi_s);
    s1_d.is_inf   = pinf_s | cc_s[1];
    s1_d.inf_sign = pinf_s ? sp_s : sc_s;
    s1_d.sp       = sp_s;
    s1_d.pzero    = ca_s[0] | cb_s[0];
    s1_d.pe       = {{(EW-EXP_W){1'b0}}, a_s[W-2:MAN_W]} + {{(EW-EXP_W){1'b0}}, b_s[W-2:MAN_W]} - BIAS;
    s1_d.pm       = {1'b1, a_s[MAN_W-1:0]} * {1'b1, b_s[MAN_W-1:0]};
    s1_d.sc       = sc_s;
    s1_d.czero    = cc_s[0];
    s1_d.ce       = c_s[W-2:MAN_W];
    s1_d.cm       = {1'b1, c_s[MAN_W-1:0]};
  end

  // S2: both terms normalised to a leading one at bit PW-1, smaller one shifted right with sticky.
  always_comb begin
    pn_e_s  = r1_r.pe + {{(EW-1){1'b0}}, r1_r.pm[PW-1]};
    pn_m_s  = r1_r.pzero ? '0 : (r1_r.pm[PW-1] ? r1_r.pm : {r1_r.pm[PW-2:0], 1'b0});
    cn_e_s  = {{(EW-EXP_W){1'b0}}, r1_r.ce};
    cn_m_s  = r1_r.czero ? '0 : {r1_r.cm, {P{1'b0}}};
    p_big_s = ~r1_r.pzero & (r1_r.czero | (pn_e_s >= cn_e_s));
    if (p_big_s) begin
      s2_d.sx = r1_r.sp;
      s2_d.ex = pn_e_s;
      s2_d.mx = {pn_m_s, 3'b000};
      ye_s    = cn_e_s;
      ym_s    = cn_m_s;
    end else begin
      s2_d.sx = r1_r.sc;
      s2_d.ex = cn_e_s;
      s2_d.mx = {cn_m_s, 3'b000};
      ye_s    = pn_e_s;
      ym_s    = pn_m_s;
    end
    d_s     = s2_d.ex - ye_s;
    shamt_s = (d_s[EW-1] | (d_s > WE_S)) ? SHW'(WE) : d_s[SHW-1:0];
    ext_s   = {ym_s, 3'b000};
    mask_s  = ~({WE{1'b1}} << shamt_s);
    s2_d.my = (ext_s >> shamt_s) | {{(WE-1){1'b0}}, |(ext_s & mask_s)};
    s2_d.sub      = r1_r.sp ^ r1_r.sc;
    s2_d.zsign    = r1_r.sp & r1_r.sc;
    s2_d.is_nan   = r1_r.is_nan;
    s2_d.is_nv    = r1_r.is_nv;
    s2_d.is_inf   = r1_r.is_inf;
    s2_d.inf_sign = r1_r.inf_sign;
  end

  // S3: signed-magnitude add, normalise, round to nearest even, pack with specials.
  always_comb begin
    if (!r2_r.sub) begin
      sum_s   = {1'b0, r2_r.mx} + {1'b0, r2_r.my};
      rsign_s = r2_r.sx;
    end else if (r2_r.mx >= r2_r.my) begin
      sum_s   = {1'b0, r2_r.mx - r2_r.my};
      rsign_s = r2_r.sx;
    end else begin
      sum_s   = {1'b0, r2_r.my - r2_r.mx};
      rsign_s = ~r2_r.sx;
    end
    lz_s   = lzc(sum_s);
    norm_s = sum_s << lz_s;
    er_s   = r2_r.ex + ONE_E - {{(EW-LZW){1'b0}}, lz_s};
    top_s  = norm_s[WE -: P];
    g_s    = norm_s[WE-P];
    st_s   = |norm_s[WE-P-1:0];
    inc_s  = g_s & (st_s | top_s[0]);
    rm_s   = {1'b0, top_s} + {{P{1'b0}}, inc_s};
    erf_s  = er_s + {{(EW-1){1'b0}}, rm_s[P]};
    ov_d   = 1'b0;
    nv_d   = 1'b0;
    if (r2_r.is_nan) begin
      res_d = QNAN;
      nv_d  = r2_r.is_nv;
    end else if (r2_r.is_inf) begin
      res_d = {r2_r.inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (sum_s == '0) begin
      res_d = {r2_r.zsign, {(W-1){1'b0}}};
    end else if (erf_s >= EMAX) begin
      res_d = {rsign_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ov_d  = 1'b1;
    end else if (erf_s[EW-1] | (erf_s == '0)) begin
      res_d = {rsign_s, {(W-1){1'b0}}};
    end else begin
      res_d = {rsign_s, erf_s[EXP_W-1:0], rm_s[MAN_W-1:0]};
    end
  end

  // Stage registers, output registers and sticky flags; data only moves with a valid occupant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r  <= 1'b0;
      v2_r  <= 1'b0;
      v3_r  <= 1'b0;
      r1_r  <= '0;
      r2_r  <= '0;
      res_r <= '0;
      ov_r  <= 1'b0;
      nv_r  <= 1'b0;
      ovs_r <= 1'b0;
      nvs_r <= 1'b0;
    end else begin
      if (load1_s) v1_r <= io.in_valid;
      if (load1_s && io.in_valid) r1_r <= s1_d;
      if (load2_s) v2_r <= v1_r;
      if (load2_s && v1_r) r2_r <= s2_d;
      if (load3_s) v3_r <= v2_r;
      if (load3_s && v2_r) begin
        res_r <= res_d;
        ov_r  <= ov_d;
        nv_r  <= nv_d;
      end
      ovs_r <= (v3_r & io.out_ready & ov_r) | (ovs_r & ~io.flag_clr);
      nvs_r <= (v3_r & io.out_ready & nv_r) | (nvs_r & ~io.flag_clr);
    end
  end

  assign io.out_valid = v3_r;
  assign io.result    = res_r;
  assign io.ov        = ov_r;
  assign io.nv        = nv_r;
  assign io.ov_sticky = ovs_r;
  assign io.nv_sticky = nvs_r;
endmodule

// File: tb/tb_fma_pipe_param.sv
// Directed-vector bench for fma_pipe_param (bfloat16): table of hand-computed results plus handshake/reset sequences.
module tb_fma_pipe_param;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fma_pipe_param_if #(.EXP_W(8), .MAN_W(7)) bus ();

  fma_pipe_param #(.EXP_W(8), .MAN_W(7), .FLUSH_DENORM(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [1:0]  op;
    logic        np;
    logic        nc;
    logic [15:0] res;
    logic        ov;
    logic        nv;
  } vec_t;

  vec_t vt[18];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int i);
    bus.a     = vt[i].a;
    bus.b     = vt[i].b;
    bus.c     = vt[i].c;
    bus.op    = vt[i].op;
    bus.neg_p = vt[i].np;
    bus.neg_c = vt[i].nc;
  endtask

  // Issue one set, measure latency, check result/flags, then the sticky flags after its transfer.
  task automatic run_vec(input int i, input bit pre_clr, input bit clr_at_xfer,
                         input logic exp_ovs, input logic exp_nvs);
    int n;
    if (pre_clr) begin
      @(negedge clk);
      bus.flag_clr = 1'b1;
      @(negedge clk);
      bus.flag_clr = 1'b0;
    end
    @(negedge clk);
    drive(i);
    bus.in_valid = 1'b1;
    #1 chk($sformatf("v%0d in_ready", i), 16'(bus.in_ready), 16'h1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk($sformatf("v%0d latency", i), 16'(n), 16'd3);
    chk($sformatf("v%0d result", i), bus.result, vt[i].res);
    chk($sformatf("v%0d ov", i), 16'(bus.ov), 16'(vt[i].ov));
    chk($sformatf("v%0d nv", i), 16'(bus.nv), 16'(vt[i].nv));
    if (clr_at_xfer) bus.flag_clr = 1'b1;
    @(negedge clk);
    bus.flag_clr = 1'b0;
    chk($sformatf("v%0d ov_sticky", i), 16'(bus.ov_sticky), 16'(exp_ovs));
    chk($sformatf("v%0d nv_sticky", i), 16'(bus.nv_sticky), 16'(exp_nvs));
    chk($sformatf("v%0d drained", i), 16'(bus.out_valid), 16'h0);
  endtask

  initial begin
    int bp_idx[6];
    logic [15:0] held;
    logic rdy;
    int sent;
    int got;
    logic seen;

    checks = 0;
    errors = 0;
    //        a         b         c         op    np    nc    res       ov    nv
    vt[0]  = '{16'h3FC0, 16'h4000, 16'h3F80, 2'd0, 1'b0, 1'b0, 16'h4080, 1'b0, 1'b0};
    vt[1]  = '{16'h4000, 16'h4040, 16'h3F80, 2'd0, 1'b0, 1'b0, 16'h40E0, 1'b0, 1'b0};
    vt[2]  = '{16'h3F80, 16'h1234, 16'h3B80, 2'd2, 1'b0, 1'b0, 16'h3F80, 1'b0, 1'b0};
    vt[3]  = '{16'h3F80, 16'h1234, 16'h3BC0, 2'd2, 1'b0, 1'b0, 16'h3F81, 1'b0, 1'b0};
    vt[4]  = '{16'h3F80, 16'h3F80, 16'hBF80, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[5]  = '{16'h7F7F, 16'h4000, 16'h3F80, 2'd1, 1'b0, 1'b0, 16'h7F80, 1'b1, 1'b0};
    vt[6]  = '{16'h7F80, 16'h0000, 16'h3F80, 2'd0, 1'b0, 1'b0, 16'h7FC0, 1'b0, 1'b1};
    vt[7]  = '{16'h7F80, 16'h3F80, 16'hFF80, 2'd0, 1'b0, 1'b0, 16'h7FC0, 1'b0, 1'b1};
    vt[8]  = '{16'h7FC1, 16'h3F80, 16'h3F80, 2'd0, 1'b0, 1'b0, 16'h7FC0, 1'b0, 1'b0};
    vt[9]  = '{16'h3FC0, 16'h4000, 16'h3F80, 2'd0, 1'b1, 1'b0, 16'hC000, 1'b0, 1'b0};
    vt[10] = '{16'h3FC0, 16'h4000, 16'h3F80, 2'd0, 1'b0, 1'b1, 16'h4000, 1'b0, 1'b0};
    vt[11] = '{16'h8000, 16'h3F80, 16'h8000, 2'd0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0};
    vt[12] = '{16'h7F80, 16'h4000, 16'h3F80, 2'd0, 1'b0, 1'b0, 16'h7F80, 1'b0, 1'b0};
    vt[13] = '{16'h8080, 16'h3F00, 16'h3F80, 2'd1, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0};
    vt[14] = '{16'h0001, 16'h3F80, 16'h3F80, 2'd0, 1'b0, 1'b0, 16'h3F80, 1'b0, 1'b0};
    vt[15] = '{16'h3F80, 16'h3F80, 16'hB380, 2'd0, 1'b0, 1'b0, 16'h3F80, 1'b0, 1'b0};
    vt[16] = '{16'h7F7F, 16'h1234, 16'h7F7F, 2'd2, 1'b0, 1'b0, 16'h7F80, 1'b1, 1'b0};
    vt[17] = '{16'h3FC0, 16'h4000, 16'h3F80, 2'd3, 1'b0, 1'b0, 16'h4080, 1'b0, 1'b0};
    bp_idx = '{0, 1, 2, 3, 9, 10};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.flag_clr = 1'b0;
    drive(0);
    #12;
    chk("rst out_valid", 16'(bus.out_valid), 16'h0);
    chk("rst result", bus.result, 16'h0000);
    chk("rst ov", 16'(bus.ov), 16'h0);
    chk("rst nv", 16'(bus.nv), 16'h0);
    chk("rst ov_sticky", 16'(bus.ov_sticky), 16'h0);
    chk("rst nv_sticky", 16'(bus.nv_sticky), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst in_ready", 16'(bus.in_ready), 16'h1);

    for (int i = 0; i < 18; i++) run_vec(i, 1'b1, 1'b0, vt[i].ov, vt[i].nv);

    // sticky persistence, clear, and set-wins-over-clear
    run_vec(5, 1'b1, 1'b0, 1'b1, 1'b0);
    run_vec(0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.flag_clr = 1'b1;
    @(negedge clk);
    bus.flag_clr = 1'b0;
    chk("clr ov_sticky", 16'(bus.ov_sticky), 16'h0);
    run_vec(6, 1'b0, 1'b1, 1'b0, 1'b1);

    // back-pressure: six sets against a stalled sink, then release
    bus.out_ready = 1'b0;
    sent = 0;
    got = 0;
    held = 16'h0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      if (cyc == 8) bus.out_ready = 1'b1;
      if (sent < 6) begin
        drive(bp_idx[sent]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      rdy = bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("bp out%0d", got), bus.result, vt[bp_idx[got]].res);
        got++;
      end
      if (cyc == 6) begin
        chk("bp accepts", 16'(sent), 16'd3);
        chk("bp in_ready", 16'(rdy), 16'h0);
        chk("bp out_valid", 16'(bus.out_valid), 16'h1);
        held = bus.result;
      end
      if (cyc == 7) chk("bp hold", bus.result, held);
      @(posedge clk);
      if (bus.in_valid && rdy) sent++;
    end
    chk("bp count", 16'(got), 16'd6);
    @(negedge clk);
    bus.in_valid = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("bp no dup", 16'(seen), 16'h0);

    // reset while two sets are in flight
    @(negedge clk);
    drive(0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst pre valid", 16'(bus.out_valid), 16'h1);
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", 16'(bus.out_valid), 16'h0);
    chk("midrst result", bus.result, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst no stale", 16'(seen), 16'h0);
    run_vec(1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
